// File: rtl/window_pkg.sv
// Shared definitions for the K x K window border stage.
//   MODE_*   : run-time border mode encodings (3 is reserved and behaves as zero)
//   state_t  : frame FSM state
//   tap_idx  : flattened tap index of window position (i, j)
package window_pkg;

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_REPL  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int tap_idx(input int i, input int j, input int k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster position of the window centre currently presented.
//   clk, rst : clock, synchronous active-high reset
//   adv      : a window is consumed this cycle; step to the next position
//   restart  : this window is treated as (0,0), whatever the stored position
//   row, col : effective position of the current window
//   last     : current window is (ROWS-1, COLS-1)
module window_pos_counter #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          restart,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  assign row  = restart ? '0 : row_q;
  assign col  = restart ? '0 : col_q;
  assign last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

  // Successor is taken from the effective position so a restart window
  // is followed by (0,1).
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv) begin
      if (last) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col == CW'(COLS - 1)) begin
        row_q <= row + 1'b1;
        col_q <= '0;
      end else begin
        row_q <= row;
        col_q <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_modulate_kxk.sv
// Border handling for K x K sliding windows over a ROWS x COLS image.
// Taps falling outside the image are replaced by zero, the nearest in-image
// tap of the same window (replicate) or PAD_VALUE, selected per frame.
//   clk, rst  : clock, synchronous active-high reset
//   valid_i   : window_i holds a window
//   sof_i     : with valid_i, this window is (0,0); restarts the frame
//   mode_i    : border mode, latched at frame start
//   window_i  : K*K taps, tap i*K+j at [t*DW +: DW]
//   window_o  : corrected taps (1-cycle latency), valid_o qualifies
//   border_o  : some tap of window_o was substituted
//   done_o    : last window of the frame, aligned with its valid_o
//   busy_o    : frame in progress
module window_modulate_kxk
  import window_pkg::*;
#(
  parameter int            K         = 3,
  parameter int            DW        = 8,
  parameter int            ROWS      = 5,
  parameter int            COLS      = 5,
  parameter logic [DW-1:0] PAD_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              sof_i,
  input  logic [1:0]        mode_i,
  input  logic [K*K*DW-1:0] window_i,
  output logic [K*K*DW-1:0] window_o,
  output logic              valid_o,
  output logic              border_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int R  = (K - 1) / 2;
  localparam int NT = K * K;
  localparam int TW = $clog2(NT);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  state_t          state;
  logic [1:0]      mode_q;
  logic [1:0]      mode_cur;
  logic            start;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            last;
  logic [DW-1:0]   tap_in [NT];
  logic [NT*DW-1:0] win_fix;
  logic [NT-1:0]   oob;

  // A window starts a frame when idle or when sof_i resynchronises.
  assign start    = valid_i && (sof_i || state == IDLE);
  assign mode_cur = start ? mode_i : mode_q;

  window_pos_counter #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_pos (
    .clk     (clk),
    .rst     (rst),
    .adv     (valid_i),
    .restart (start),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      localparam int T = tap_idx(gi, gj, K);
      int            rr, cc, ri, ci;
      logic          tap_oob;
      logic [DW-1:0] sub;

      assign tap_in[T] = window_i[T*DW +: DW];

      // Image coordinates in int so the +/-R offset never wraps.
      always_comb begin
        rr      = int'(row) + gi - R;
        cc      = int'(col) + gj - R;
        tap_oob = (rr < 0) || (rr > ROWS - 1) || (cc < 0) || (cc > COLS - 1);
        // Clamped pixel mapped back into window coordinates.
        ri = ((rr < 0) ? 0 : (rr > ROWS - 1) ? ROWS - 1 : rr) - int'(row) + R;
        ci = ((cc < 0) ? 0 : (cc > COLS - 1) ? COLS - 1 : cc) - int'(col) + R;
        case (mode_cur)
          MODE_REPL:  sub = tap_in[TW'(ri * K + ci)];
          MODE_CONST: sub = PAD_VALUE;
          default:    sub = '0;
        endcase
      end

      assign oob[T]               = tap_oob;
      assign win_fix[T*DW +: DW]  = tap_oob ? sub : tap_in[T];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_ZERO;
      window_o <= '0;
      valid_o  <= 1'b0;
      border_o <= 1'b0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      done_o  <= valid_i && last;
      // Stays high through the done_o cycle, drops after it unless a new
      // frame follows back-to-back.
      busy_o  <= valid_i || (state == RUN);
      if (valid_i) begin
        window_o <= win_fix;
        border_o <= |oob;
        state    <= last ? IDLE : RUN;
        if (start) mode_q <= mode_i;
      end
    end
  end

endmodule

// File: tb/tb_window_modulate_kxk.sv
module tb_window_modulate_kxk;

  localparam logic [71:0]  ALL11    = {9{8'h11}};
  localparam logic [71:0]  SEQ      = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0]  E_ZERO00 = 72'h11_11_00_11_11_00_00_00_00;
  localparam logic [71:0]  E_REPL00 = 72'h09_08_08_06_05_05_06_05_05;
  localparam logic [71:0]  E_REPL44 = 72'h05_05_04_05_05_04_02_02_01;
  localparam logic [199:0] W33      = {25{8'h33}};
  localparam logic [199:0] E_C03    = {{15{8'h33}}, {10{8'hAA}}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid_a, sof_a;
  logic [1:0]  mode_a;
  logic [71:0] win_a, wo_a;
  logic        vo_a, bo_a, do_a, busy_a;

  logic         valid_b, sof_b;
  logic [1:0]   mode_b;
  logic [199:0] win_b, wo_b;
  logic         vo_b, bo_b, do_b, busy_b;

  window_modulate_kxk #(.K(3), .DW(8), .ROWS(5), .COLS(5), .PAD_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_a), .sof_i(sof_a), .mode_i(mode_a),
    .window_i(win_a), .window_o(wo_a), .valid_o(vo_a), .border_o(bo_a),
    .done_o(do_a), .busy_o(busy_a)
  );

  window_modulate_kxk #(.K(5), .DW(8), .ROWS(7), .COLS(7), .PAD_VALUE(8'hAA)) dut2 (
    .clk(clk), .rst(rst), .valid_i(valid_b), .sof_i(sof_b), .mode_i(mode_b),
    .window_i(win_b), .window_o(wo_b), .valid_o(vo_b), .border_o(bo_b),
    .done_o(do_b), .busy_o(busy_b)
  );

  int errors = 0;
  int checks = 0;
  int v_cnt, d_cnt;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic sof, input logic [1:0] m, input logic [71:0] w);
    valid_a = 1'b1; sof_a = sof; mode_a = m; win_a = w;
    @(posedge clk); #1;
    valid_a = 1'b0; sof_a = 1'b0;
  endtask

  task automatic send_b(input logic sof, input logic [1:0] m, input logic [199:0] w);
    valid_b = 1'b1; sof_b = sof; mode_b = m; win_b = w;
    @(posedge clk); #1;
    valid_b = 1'b0; sof_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    valid_a = 0; sof_a = 0; mode_a = 0; win_a = '0;
    valid_b = 0; sof_b = 0; mode_b = 0; win_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_window", wo_a, '0);
    chk("rst_valid", vo_a, 0);
    chk("rst_border", bo_a, 0);
    chk("rst_done", do_a, 0);
    chk("rst_busy", busy_a, 0);
    rst = 1'b0;

    // Zero mode: corner window then an interior window.
    send_a(0, 2'd0, ALL11);
    chk("zero_00_win", wo_a, E_ZERO00);
    chk("zero_00_border", bo_a, 1);
    chk("zero_00_valid", vo_a, 1);
    chk("zero_00_busy", busy_a, 1);
    chk("zero_00_done", do_a, 0);
    repeat (11) send_a(0, 2'd0, ALL11);
    send_a(0, 2'd0, ALL11);
    chk("zero_22_win", wo_a, ALL11);
    chk("zero_22_border", bo_a, 0);

    // Resync into replicate mode mid-frame, then run to (4,4) with mode toggling.
    send_a(1, 2'd1, SEQ);
    chk("repl_00_win", wo_a, E_REPL00);
    chk("repl_00_border", bo_a, 1);
    chk("repl_00_done", do_a, 0);
    for (int k = 0; k < 23; k++) begin
      send_a(0, (k % 2 == 0) ? 2'd0 : 2'd2, SEQ);
      chk("repl_mid_done", do_a, 0);
    end
    send_a(0, 2'd0, SEQ);
    chk("repl_44_win", wo_a, E_REPL44);
    chk("repl_44_done", do_a, 1);
    chk("repl_44_busy", busy_a, 1);
    @(posedge clk); #1;
    chk("bubble_valid", vo_a, 0);
    chk("bubble_done", do_a, 0);
    chk("bubble_busy", busy_a, 0);
    chk("bubble_hold", wo_a, E_REPL44);

    // Full frame with random gaps; mode latched as replicate on window 0.
    v_cnt = 0; d_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        if (vo_a) v_cnt++;
        if (do_a) d_cnt++;
      end
      send_a(0, (k == 0) ? 2'd1 : 2'(k % 3), SEQ);
      if (vo_a) v_cnt++;
      if (do_a) d_cnt++;
      chk("frame_done", do_a, (k == 24) ? 1 : 0);
    end
    chk("frame_last_win", wo_a, E_REPL44);
    chk("frame_valid_cnt", v_cnt, 25);
    chk("frame_done_cnt", d_cnt, 1);
    @(posedge clk); #1;
    chk("frame_busy_drop", busy_a, 0);

    // Reset in the middle of a frame.
    repeat (12) send_a(0, 2'd0, ALL11);
    rst = 1'b1; valid_a = 1'b1; win_a = ALL11;
    @(posedge clk); #1;
    rst = 1'b0; valid_a = 1'b0;
    chk("midrst_window", wo_a, '0);
    chk("midrst_valid", vo_a, 0);
    chk("midrst_border", bo_a, 0);
    chk("midrst_done", do_a, 0);
    chk("midrst_busy", busy_a, 0);
    send_a(0, 2'd0, ALL11);
    chk("midrst_restart", wo_a, E_ZERO00);

    // Resync at (2,3), then the frame completes after 25 windows total.
    repeat (12) send_a(0, 2'd0, ALL11);
    send_a(1, 2'd0, ALL11);
    chk("sync_win", wo_a, E_ZERO00);
    chk("sync_done", do_a, 0);
    chk("sync_border", bo_a, 1);
    for (int k = 0; k < 24; k++) begin
      send_a(0, 2'd0, ALL11);
      chk("sync_frame_done", do_a, (k == 23) ? 1 : 0);
    end
    // Back-to-back frame, no idle cycle.
    send_a(0, 2'd0, ALL11);
    chk("b2b_win", wo_a, E_ZERO00);
    chk("b2b_busy", busy_a, 1);
    chk("b2b_done", do_a, 0);

    // Constant mode, K=5 on 7x7; mode_i changes after the first window are ignored.
    send_b(1, 2'd2, W33);
    send_b(0, 2'd0, W33);
    send_b(0, 2'd0, W33);
    send_b(0, 2'd0, W33);
    chk("const_03_win", wo_b, E_C03);
    chk("const_03_border", bo_b, 1);
    repeat (20) send_b(0, 2'd1, W33);
    send_b(0, 2'd0, W33);
    chk("const_33_win", wo_b, W33);
    chk("const_33_border", bo_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
